fir_shiftadd_approx_pipe: RTL and testbench

Parametrised multiplierless FIR filter with coefficients of the form 2^-SHIFT_i. The TAPS terms are summed in a registered binary adder tree built from approximate Sklansky-style adders. The lower APPROX_K bit positions ignore carry propagation; this is selectable per sample at run time. It sits in the filter datapath as the successor of the fixed 5-tap/16-bit FIR and adds three things: a valid handshake, a pipelined tree, and an exact/approximate mode.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/sklansky_approx_add.sv | 61 ++++++
 rtl/fir_shiftadd_approx_pipe.sv | 116 +++++++++++
 tb/tb_fir_shiftadd_approx_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the shift-add FIR datapath.
//   SHIFT_W      width of one per-tap shift field in the packed SHIFTS parameter
//   MAX_TAPS     largest supported tap count (sizes the SHIFTS extract helper)
//   tree_levels  number of registered adder-tree levels for a tap count
//   level_count  number of live nodes at a given tree level
//   shift_field  extract the shift amount of tap i from a packed SHIFTS vector
package fir_pkg;
  localparam int SHIFT_W  = 5;
  localparam int MAX_TAPS = 16;

  function automatic int tree_levels(input int taps);
    return (taps <= 1) ? 0 : $clog2(taps);
  endfunction

  // Pairwise reduction: each level halves the node count, rounding up.
  function automatic int level_count(input int taps, input int lvl);
    return (taps + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic int shift_field(input logic [MAX_TAPS*SHIFT_W-1:0] shifts,
                                     input int i);
    return int'(shifts[i*SHIFT_W +: SHIFT_W]);
  endfunction
endpackage

// File: rtl/sklansky_approx_add.sv
// Combinational DATA_W-bit adder with a Sklansky parallel-prefix carry network.
// When approx_en is high the lowest APPROX_K bit positions take only the local
// generate of the bit below as their carry (no propagation); above that the
// carry chain is exact. Carry-out of the MSB is dropped (modulo 2^DATA_W).
//   a, b       addends
//   approx_en  1 = truncated low carries, 0 = exact sum
//   sum        result
module sklansky_approx_add #(
  parameter int DATA_W   = 16,
  parameter int APPROX_K = 6
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              approx_en,
  output logic [DATA_W-1:0] sum
);
  localparam int NL = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] p, g, pk;
  logic [DATA_W-1:0] gv, pv, gn, pn;

  assign p = a ^ b;
  assign g = a & b;

  // Killing propagate below APPROX_K makes every carry into bits 1..APPROX_K
  // collapse to the generate of the bit beneath it, and hands the exact
  // recurrence above APPROX_K that truncated carry as its seed.
  genvar i;
  generate
    for (i = 0; i < DATA_W; i++) begin : g_pk
      if (i < APPROX_K) begin : g_cut
        assign pk[i] = p[i] & ~approx_en;
      end else begin : g_keep
        assign pk[i] = p[i];
      end
    end
  endgenerate

  // Sklansky prefix: at level l every bit with bit l of its index set merges
  // with the top bit of the preceding 2^l-wide block.
  always_comb begin
    gv = g;
    pv = pk;
    gn = g;
    pn = pk;
    for (int l = 0; l < NL; l++) begin
      gn = gv;
      pn = pv;
      for (int k = 0; k < DATA_W; k++) begin
        if (((k >> l) & 1) == 1) begin
          gn[k] = gv[k] | (pv[k] & gv[((k >> l) << l) - 1]);
          pn[k] = pv[k] & pv[((k >> l) << l) - 1];
        end
      end
      gv = gn;
      pv = pn;
    end
    // gv[j] is the group generate over bits j..0, i.e. the carry into bit j+1.
    sum = p ^ (gv << 1);
  end
endmodule

// File: rtl/fir_shiftadd_approx_pipe.sv
// Multiplierless FIR: y = sum_i (tap_i >> SHIFT_i), summed in a registered
// binary tree of approximate/exact Sklansky adders, mode chosen per sample.
//   clk, rst   clock; synchronous active-high reset
//   in_valid   accept x (and approx_en) this cycle
//   x          input sample
//   approx_en  adder mode for this sample (1 = approximate low carries)
//   out_valid  one-cycle pulse, dataout just updated
//   dataout    filter result, held between pulses
// Latency is tree_levels(TAPS)+1 cycles; one result per cycle back-to-back.
module fir_shiftadd_approx_pipe
  import fir_pkg::*;
#(
  parameter int                       DATA_W   = 16,
  parameter int                       TAPS     = 5,
  parameter logic [TAPS*SHIFT_W-1:0]  SHIFTS   = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5},
  parameter int                       APPROX_K = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x,
  input  logic              approx_en,
  output logic              out_valid,
  output logic [DATA_W-1:0] dataout
);
  localparam int L = tree_levels(TAPS);
  localparam logic [MAX_TAPS*SHIFT_W-1:0] SHIFTS_X = (MAX_TAPS*SHIFT_W)'(SHIFTS);

  logic [TAPS-2:0][DATA_W-1:0] d;
  logic [TAPS-1:0][DATA_W-1:0] term;
  logic [TAPS-1:0][DATA_W-1:0] node [0:L];
  logic [L:0]                  vld_pipe;
  logic [L-1:0]                mode_pipe;

  // Terms use the delay line before this cycle's shift.
  genvar t;
  generate
    for (t = 0; t < TAPS; t++) begin : g_term
      localparam int SH = shift_field(SHIFTS_X, t);
      if (t == 0) begin : g_x
        assign term[t] = x >> SH;
      end else begin : g_d
        assign term[t] = d[t-1] >> SH;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      d <= '0;
    end else if (in_valid) begin
      d[0] <= x;
      for (int k = 1; k < TAPS-1; k++) d[k] <= d[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      node[0] <= '0;
    end else if (in_valid) begin
      node[0] <= term;
    end
  end

  // Valid and mode ride alongside the tree; mode_pipe[l] steers level l+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      mode_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[L-1:0], in_valid};
      if (in_valid) mode_pipe[0] <= approx_en;
      for (int k = 1; k < L; k++) mode_pipe[k] <= mode_pipe[k-1];
    end
  end

  genvar l, j;
  generate
    for (l = 1; l <= L; l++) begin : g_lvl
      localparam int NP = level_count(TAPS, l-1);
      for (j = 0; j < TAPS; j++) begin : g_node
        if (2*j+1 < NP) begin : g_add
          logic [DATA_W-1:0] s;
          sklansky_approx_add #(.DATA_W(DATA_W), .APPROX_K(APPROX_K)) u_add (
            .a         (node[l-1][2*j]),
            .b         (node[l-1][2*j+1]),
            .approx_en (mode_pipe[l-1]),
            .sum       (s)
          );
          always_ff @(posedge clk) begin
            if (rst) node[l][j] <= '0;
            else     node[l][j] <= s;
          end
        end else if (2*j < NP) begin : g_pass
          // Odd element out: carried to the next level unchanged.
          always_ff @(posedge clk) begin
            if (rst) node[l][j] <= '0;
            else     node[l][j] <= node[l-1][2*j];
          end
        end else begin : g_idle
          always_ff @(posedge clk) node[l][j] <= '0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dataout   <= '0;
    end else begin
      out_valid <= vld_pipe[L];
      if (vld_pipe[L]) dataout <= node[L][0];
    end
  end
endmodule

// File: tb/tb_fir_shiftadd_approx_pipe.sv
module tb_fir_shiftadd_approx_pipe;
  localparam int K   = 6;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, approx_en, out_valid;
  logic [15:0] x, dataout;

  logic        vz, mz, ovz;
  logic [15:0] xz, dz;

  logic [15:0] aa, bb, ss;
  logic        am;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {logic [15:0] data; int at;} exp_t;
  exp_t q[$];
  logic [15:0] md [0:3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_shiftadd_approx_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .approx_en(approx_en),
    .out_valid(out_valid), .dataout(dataout)
  );

  fir_shiftadd_approx_pipe #(.SHIFTS(25'd0)) dut_z (
    .clk(clk), .rst(rst), .in_valid(vz), .x(xz), .approx_en(mz),
    .out_valid(ovz), .dataout(dz)
  );

  sklansky_approx_add #(.DATA_W(16), .APPROX_K(K)) u_add (
    .a(aa), .b(bb), .approx_en(am), .sum(ss)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Bit-serial reference: ripple carry, with the carry into bits 1..K
  // replaced by the lower bit's generate in approximate mode.
  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b,
                                        input logic m);
    logic [15:0] s;
    logic c, pp, gg;
    c = 1'b0;
    s = '0;
    for (int n = 0; n < 16; n++) begin
      pp = a[n] ^ b[n];
      gg = a[n] & b[n];
      s[n] = pp ^ c;
      if (m && (n + 1) <= K) c = gg;
      else                   c = gg | (pp & c);
    end
    return s;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] xx, input logic m);
    logic [15:0] t0, t1, t2, t3, t4, s01, s23, s03;
    t0 = xx >> 5;
    t1 = md[0] >> 4;
    t2 = md[1] >> 3;
    t3 = md[2] >> 2;
    t4 = md[3] >> 1;
    s01 = m_add(t0, t1, m);
    s23 = m_add(t2, t3, m);
    s03 = m_add(s01, s23, m);
    return m_add(s03, t4, m);
  endfunction

  task automatic step(input logic v, input logic [15:0] xx, input logic m,
                      input logic hand, input logic [15:0] hv);
    logic [15:0] e;
    in_valid  = v;
    x         = xx;
    approx_en = m;
    e = hand ? hv : model(xx, m);
    @(posedge clk);
    #1;
    if (v) begin
      q.push_back('{e, cyc + LAT});
      md[3] = md[2]; md[2] = md[1]; md[1] = md[0]; md[0] = xx;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d results still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest pending result,
  // including the edge it was due on; overdue results count as missed.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].at < cyc) begin
      e = q.pop_front();
      n_total++;
      $display("FAIL missed_out_valid: none at cycle %0d, expected data %h", e.at, e.data);
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL spurious_out_valid: got dataout %h at cycle %0d, expected no pulse", dataout, cyc);
      end else begin
        e = q.pop_front();
        chk("dataout", 32'(dataout), 32'(e.data));
        chk("out_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  logic [15:0] va [0:2] = '{16'h003F, 16'h0FFF, 16'h0020};
  logic [15:0] vb [0:2] = '{16'h0001, 16'h0001, 16'h0020};
  logic [15:0] ea [0:2] = '{16'h003C, 16'h0FFC, 16'h0040};
  logic [15:0] ee [0:2] = '{16'h0040, 16'h1000, 16'h0040};
  logic [15:0] imp [0:5] = '{16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h0000};
  logic        gap [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; approx_en = 1'b0;
    vz = 1'b1; xz = 16'h8000; mz = 1'b0;
    aa = '0; bb = '0; am = 1'b0;
    for (int k = 0; k < 4; k++) md[k] = '0;

    // Adder unit vectors, approximate then exact.
    for (int k = 0; k < 3; k++) begin
      aa = va[k]; bb = vb[k];
      am = 1'b1; #1; chk("add_approx", 32'(ss), 32'(ea[k]));
      am = 1'b0; #1; chk("add_exact", 32'(ss), 32'(ee[k]));
    end

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_dataout", 32'(dataout), 32'd0);

    // Impulse response, exact mode.
    step(1'b1, 16'h4000, 1'b0, 1'b1, imp[0]);
    for (int k = 1; k < 6; k++) step(1'b1, 16'h0000, 1'b0, 1'b1, imp[k]);

    // Constant full-scale input: ramp from model, then steady state by hand.
    for (int k = 0; k < 4; k++) step(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) step(1'b1, 16'hFFFF, 1'b0, 1'b1, 16'hF7FB);
    drain();

    // Gapped valid with random samples.
    for (int k = 0; k < 7; k++) step(gap[k], 16'($urandom), 1'b0, 1'b0, 16'h0);
    drain();

    // Mode toggling every sample.
    for (int k = 0; k < 10; k++) step(1'b1, 16'($urandom), 1'(k % 2), 1'b0, 16'h0);
    drain();

    // All-zero-shift build: five copies of 0x8000 wrap back to 0x8000.
    chk("zero_shift_valid", 32'(ovz), 32'd1);
    chk("zero_shift_sum", 32'(dz), 32'h8000);
    mz = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("zero_shift_approx_sum", 32'(dz), 32'h8000);

    // Reset with three samples in flight.
    for (int k = 0; k < 3; k++) step(1'b1, 16'($urandom) | 16'h0400, 1'b0, 1'b0, 16'h0);
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) md[k] = '0;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_dataout", 32'(dataout), 32'd0);
    for (int k = 0; k < 6; k++) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 16'h4000, 1'b0, 1'b1, 16'h0200);
    step(1'b1, 16'h2000, 1'b0, 1'b1, 16'h0500);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
